relu_vec: RTL and testbench

Parametrised, pipelined, multi-channel activation unit for the feedforward datapath. Each cycle it accepts a vector of CHANNELS IEEE-754 single-precision values and applies ReLU, the ReLU derivative or, optionally, leaky ReLU to every lane. Results come out two cycles later. It sits between the neuron accumulate stage and the next layer's input buffer, and it replaces single-value rdy/done activation with a full valid/ready stream.

---
 rtl/relu_vec_if.sv | 31 +++
 rtl/relu_vec.sv | 151 +++++++++++++++
 tb/tb_relu_vec.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/relu_vec_if.sv
// rtl/relu_vec_if.sv - valid/ready vector stream bundle for relu_vec
// Purpose: groups the input and output vector handshakes of the activation unit.
// Parameter: CHANNELS - lanes per vector (each lane is one 32-bit float).
// Signals:
//   in_valid/in_ready/in_data/in_mode     - input vector handshake, data and per-vector mode
//   out_valid/out_ready/out_data          - result vector handshake and data
// Modports:
//   master - producer of input vectors / consumer of results (upstream + downstream side)
//   slave  - the activation unit itself
`timescale 1ns/1ps
interface relu_vec_if #(
   parameter int CHANNELS = 4
);
   logic                     in_valid;
   logic                     in_ready;
   logic [CHANNELS*32-1:0]   in_data;
   logic [1:0]               in_mode;
   logic                     out_valid;
   logic                     out_ready;
   logic [CHANNELS*32-1:0]   out_data;

   modport master (
      output in_valid, in_data, in_mode, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, in_mode, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/relu_vec.sv
// rtl/relu_vec.sv - two-stage pipelined multi-lane ReLU / derivative / leaky ReLU unit
// Purpose: applies a per-vector activation function to CHANNELS IEEE-754 single lanes.
//   Mode 0 relu, 1 relu derivative, 2 leaky relu, 3 pass-through; NaN lanes become 0x7FC00000.
// Optional feature: define RELU_LEAKY_EN to build the leaky exponent path for mode 2
//   (slope 2^-LEAK_SHIFT); without it mode 2 behaves exactly as mode 0.
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   bus       - relu_vec_if.slave: input/output vector streams
//   busy      - a pipeline stage holds a vector
//   vec_count - output handshakes since reset, wraps
`timescale 1ns/1ps
module relu_vec #(
   parameter int CHANNELS   = 4,
   parameter int LEAK_SHIFT = 4,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   relu_vec_if.slave        bus,
   output logic             busy,
   output logic [CNT_W-1:0] vec_count
);
   localparam int          W          = CHANNELS * 32;
   localparam logic [31:0] QNAN       = 32'h7FC0_0000;
   localparam logic [31:0] ONE        = 32'h3F80_0000;
   localparam logic [31:0] NEG_ZERO   = 32'h8000_0000;
   localparam logic [1:0]  MODE_RELU  = 2'd0;
   localparam logic [1:0]  MODE_DERIV = 2'd1;
   localparam logic [1:0]  MODE_LEAKY = 2'd2;
   localparam logic [1:0]  MODE_PASS  = 2'd3;
`ifdef RELU_LEAKY_EN
   localparam logic [7:0]  LS8        = 8'(LEAK_SHIFT);
`endif

   if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
      $error("relu_vec: CHANNELS must be 1..16");
   end
   if (LEAK_SHIFT < 1 || LEAK_SHIFT > 8) begin : g_bad_shift
      $error("relu_vec: LEAK_SHIFT must be 1..8");
   end

   logic                s1_valid;
   logic [W-1:0]        s1_data;
   logic [1:0]          s1_mode;
   logic [CHANNELS-1:0] s1_sign, s1_zero, s1_nan;
   logic                s2_valid;
   logic [W-1:0]        s2_data;
   logic [W-1:0]        s2_next;
   logic [CHANNELS-1:0] in_sign, in_zero, in_nan;
   logic                s2_adv;
   logic                out_fire;

   // S2 may take a new vector when it is empty or its current one leaves this cycle;
   // S1 moves in lockstep, so in_ready never looks at in_valid.
   assign out_fire     = s2_valid && bus.out_ready;
   assign s2_adv       = !s2_valid || bus.out_ready;
   assign bus.in_ready = !s1_valid || s2_adv;

   assign bus.out_valid = s2_valid;
   assign bus.out_data  = s2_data;
   assign busy          = s1_valid | s2_valid;

   // Lane classification done on the way into S1 so S2 only selects results.
   always_comb begin
      in_sign = '0;
      in_zero = '0;
      in_nan  = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         in_sign[i] = bus.in_data[32*i+31];
         in_zero[i] = (bus.in_data[32*i+23 +: 8] == 8'h00);
         in_nan[i]  = (bus.in_data[32*i+23 +: 8] == 8'hFF) && (bus.in_data[32*i +: 23] != 23'd0);
      end
   end

   function automatic logic [31:0] lane_fn(input logic [31:0] x, input logic [1:0] mode,
                                           input logic sign, input logic zero, input logic nan);
      logic [1:0]  eff_mode;
      logic [31:0] r;
`ifdef RELU_LEAKY_EN
      eff_mode = mode;
`else
      eff_mode = (mode == MODE_LEAKY) ? MODE_RELU : mode;
`endif
      if (nan)
         r = QNAN;
      else if (eff_mode == MODE_PASS)
         r = x;
      else if (zero)
         r = (eff_mode == MODE_LEAKY) ? {sign, 31'b0} : 32'h0;
      else begin
         case (eff_mode)
            MODE_RELU:  r = sign ? 32'h0 : x;
            MODE_DERIV: r = sign ? 32'h0 : ONE;
            default: begin
`ifdef RELU_LEAKY_EN
               // Scaling by 2^-LEAK_SHIFT is an exponent subtract; results that would
               // go denormal are flushed to -0, and -inf stays -inf.
               if (!sign || x[30:23] == 8'hFF)
                  r = x;
               else if (x[30:23] > LS8)
                  r = {1'b1, x[30:23] - LS8, x[22:0]};
               else
                  r = NEG_ZERO;
`else
               r = sign ? 32'h0 : x;
`endif
            end
         endcase
      end
      return r;
   endfunction

   always_comb begin
      s2_next = '0;
      for (int i = 0; i < CHANNELS; i++)
         s2_next[32*i +: 32] = lane_fn(s1_data[32*i +: 32], s1_mode, s1_sign[i], s1_zero[i], s1_nan[i]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_data   <= '0;
         s1_mode   <= '0;
         s1_sign   <= '0;
         s1_zero   <= '0;
         s1_nan    <= '0;
         s2_valid  <= 1'b0;
         s2_data   <= '0;
         vec_count <= '0;
      end else begin
         if (bus.in_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
               s1_data <= bus.in_data;
               s1_mode <= bus.in_mode;
               s1_sign <= in_sign;
               s1_zero <= in_zero;
               s1_nan  <= in_nan;
            end
         end
         if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid)
               s2_data <= s2_next;
         end
         if (out_fire)
            vec_count <= vec_count + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_relu_vec.sv
// tb/tb_relu_vec.sv - self-checking bench for relu_vec (2 lanes, 4-bit vector counter)
`timescale 1ns/1ps
module tb_relu_vec;
   localparam int         CH = 2;
   localparam int         W  = CH * 32;
   localparam logic [7:0] LS = 8'd4;

   logic          clk;
   logic          rst_n;
   logic          busy;
   logic [3:0]    vec_count;
   int            total = 0;
   int            bad   = 0;
   logic [W-1:0]  exp_q[$];
   logic          stall_prev = 1'b0;
   logic [W-1:0]  hold_data  = '0;
   logic [31:0]   specials [10] = '{32'h0000_0000, 32'h8000_0000, 32'h7F80_0000, 32'hFF80_0000,
                                    32'h7FC0_0001, 32'h0000_0001, 32'h8080_0000, 32'h8280_0000,
                                    32'h8200_0000, 32'hC0E8_0000};

   relu_vec_if #(.CHANNELS(CH)) bus ();

   relu_vec #(.CHANNELS(CH), .LEAK_SHIFT(4), .CNT_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .busy      (busy),
      .vec_count (vec_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Reference lane function written from the rule list, rule order top to bottom.
   function automatic logic [31:0] ref_lane(input logic [31:0] x, input logic [1:0] mode);
      logic       s;
      logic [7:0] e;
      logic [1:0] m;
      s = x[31];
      e = x[30:23];
      m = mode;
      if (e == 8'hFF && x[22:0] != 23'd0) return 32'h7FC0_0000;
      if (m == 2'd3) return x;
`ifndef RELU_LEAKY_EN
      if (m == 2'd2) m = 2'd0;
`endif
      if (e == 8'h00) return (m == 2'd2) ? {s, 31'b0} : 32'h0;
      if (m == 2'd0) return s ? 32'h0 : x;
      if (m == 2'd1) return s ? 32'h0 : 32'h3F80_0000;
      if (!s || e == 8'hFF) return x;
      if (e > LS) return {1'b1, 8'(e - LS), x[22:0]};
      return 32'h8000_0000;
   endfunction

   function automatic logic [W-1:0] ref_vec(input logic [W-1:0] d, input logic [1:0] mode);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < CH; i++) r[32*i +: 32] = ref_lane(d[32*i +: 32], mode);
      return r;
   endfunction

   function automatic logic [W-1:0] rand_vec();
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < CH; i++)
         r[32*i +: 32] = ($urandom_range(0, 2) == 0) ? specials[$urandom_range(0, 9)] : 32'($urandom);
      return r;
   endfunction

   // Scoreboard monitor: mid-cycle, so handshakes seen here complete at the next rising edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            chk("stall_hold_valid", 64'(bus.out_valid), 64'(1));
            chk("stall_hold_data", 64'(bus.out_data), 64'(hold_data));
         end
         if (!bus.in_ready)
            chk("in_ready_low_only_when_blocked", 64'(bus.out_valid && !bus.out_ready), 64'(1));
         if (bus.out_valid && bus.out_ready) begin
            chk("sb_has_entry", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) chk("sb_out_data", 64'(bus.out_data), 64'(exp_q.pop_front()));
         end
         if (bus.in_valid && bus.in_ready)
            exp_q.push_back(ref_vec(bus.in_data, bus.in_mode));
         stall_prev = bus.out_valid && !bus.out_ready;
         hold_data  = bus.out_data;
      end
   end

   // Entry and exit at #1 after a rising edge with an accepting pipeline.
   task automatic send_one(input string tag, input logic [W-1:0] d, input logic [1:0] m,
                           input logic [W-1:0] expv);
      bus.in_data   = d;
      bus.in_mode   = m;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk({tag, "_lat1_valid"}, 64'(bus.out_valid), 64'(0));
      @(posedge clk); #1;
      chk({tag, "_lat2_valid"}, 64'(bus.out_valid), 64'(1));
      chk({tag, "_data"}, 64'(bus.out_data), 64'(expv));
   endtask

   task automatic drain();
      int n;
      n = 0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      while (exp_q.size() != 0 && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain_empty", 64'(exp_q.size()), 64'(0));
   endtask

   task automatic stream(input int n, input bit toggle);
      int           sent;
      int           cyc;
      bit           acc;
      logic [W-1:0] cur;
      logic [1:0]   cur_mode;
      sent     = 0;
      cyc      = 0;
      cur      = rand_vec();
      cur_mode = 2'($urandom_range(0, 3));
      while (sent < n && cyc < 400) begin
         bus.in_valid  = 1'b1;
         bus.in_data   = cur;
         bus.in_mode   = cur_mode;
         bus.out_ready = toggle ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk); #1;
         if (acc) begin
            sent++;
            cur      = rand_vec();
            cur_mode = 2'($urandom_range(0, 3));
         end
         cyc++;
      end
      chk("stream_sent", 64'(sent), 64'(n));
      drain();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_mode   = 2'd0;
      bus.out_ready = 1'b1;
      rst_n         = 1'b0;
      #3;
      chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
      chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("rst_out_data", 64'(bus.out_data), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_vec_count", 64'(vec_count), 64'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      send_one("relu", {32'hC0E8_0000, 32'h4105_47AE}, 2'd0, {32'h0000_0000, 32'h4105_47AE});
      @(posedge clk); #1;
      chk("count_after_first", 64'(vec_count), 64'(1));

      send_one("deriv", {32'hC0E8_0000, 32'h4105_47AE}, 2'd1, {32'h0000_0000, 32'h3F80_0000});
      send_one("deriv_nan", {32'h7FC0_0001, 32'h8000_0000}, 2'd1, {32'h7FC0_0000, 32'h0000_0000});
      send_one("deriv_zero_inf", {32'h7F80_0000, 32'h0000_0000}, 2'd1, {32'h3F80_0000, 32'h0000_0000});
      send_one("relu_inf", {32'h7F80_0000, 32'hFF80_0000}, 2'd0, {32'h7F80_0000, 32'h0000_0000});
      send_one("pass", {32'h7FC0_0001, 32'h0000_0001}, 2'd3, {32'h7FC0_0000, 32'h0000_0001});
`ifdef RELU_LEAKY_EN
      send_one("leaky_a", {32'h8080_0000, 32'hC0E8_0000}, 2'd2, {32'h8000_0000, 32'hBEE8_0000});
      send_one("leaky_b", {32'hFF80_0000, 32'h4105_47AE}, 2'd2, {32'hFF80_0000, 32'h4105_47AE});
      send_one("leaky_edge", {32'h8200_0000, 32'h8280_0000}, 2'd2, {32'h8000_0000, 32'h8080_0000});
      send_one("leaky_denorm", {32'h8000_0001, 32'h0000_0000}, 2'd2, {32'h8000_0000, 32'h0000_0000});
`else
      send_one("leaky_a", {32'h8080_0000, 32'hC0E8_0000}, 2'd2, {32'h0000_0000, 32'h0000_0000});
      send_one("leaky_b", {32'hFF80_0000, 32'h4105_47AE}, 2'd2, {32'h0000_0000, 32'h4105_47AE});
      send_one("leaky_edge", {32'h8200_0000, 32'h8280_0000}, 2'd2, {32'h0000_0000, 32'h0000_0000});
      send_one("leaky_denorm", {32'h8000_0001, 32'h0000_0000}, 2'd2, {32'h0000_0000, 32'h0000_0000});
`endif
      drain();

      do_reset();
      stream(8, 1'b1);
      chk("count_after_stream", 64'(vec_count), 64'(8));

      // Two vectors in flight, then a short reset pulse between clock edges.
      bus.in_valid  = 1'b1;
      bus.in_mode   = 2'd0;
      bus.in_data   = {32'h3F80_0000, 32'h4000_0000};
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_data = {32'h4040_0000, 32'h4080_0000};
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      chk("pre_pulse_busy", 64'(busy), 64'(1));
      chk("pre_pulse_out_valid", 64'(bus.out_valid), 64'(1));
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      #0.5;
      chk("pulse_out_valid", 64'(bus.out_valid), 64'(0));
      chk("pulse_busy", 64'(busy), 64'(0));
      chk("pulse_vec_count", 64'(vec_count), 64'(0));
      chk("pulse_in_ready", 64'(bus.in_ready), 64'(1));
      #0.5;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_pulse_out_valid", 64'(bus.out_valid), 64'(0));
      send_one("post_pulse", {32'hC0E8_0000, 32'h4105_47AE}, 2'd0, {32'h0000_0000, 32'h4105_47AE});

      stream(16, 1'b0);
      chk("count_wrap", 64'(vec_count), 64'(1));
      chk("idle_busy", 64'(busy), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
